// File: rtl/off_chip_spi_flash_device_pkg.sv
// Shared opcode and FSM state constants for the SPI flash device and its
// master controller.
package off_chip_spi_flash_device_pkg;

  // Command opcodes, first byte of every frame.
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_STATUS = 8'h05;

  // FSM state encodings.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPCODE = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_STATUS = 3'd5;
  localparam logic [2:0] ST_IGNORE = 3'd6;

  // Bit-counter values marking field boundaries.
  localparam logic [5:0] OPCODE_LAST = 6'd7;
  localparam logic [5:0] ADDR_LAST   = 6'd7;
  localparam logic [5:0] STATUS_END  = 6'd8;

  // State entered after the last opcode bit has been sampled.
  function automatic logic [2:0] opcode_next_state(input logic [7:0] opcode);
    logic [2:0] nxt;
    case (opcode)
      OP_WRITE, OP_READ: nxt = ST_ADDR;
      OP_STATUS:         nxt = ST_STATUS;
      default:           nxt = ST_IGNORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/off_chip_spi_flash_shift_reg.sv
// WORD-wide shift register: serial-in at the LSB, serial-out at the MSB,
// with synchronous clear and parallel load. 'shifted' exposes the value the
// register takes on a shift, so callers can capture a field on its last bit.
module off_chip_spi_flash_shift_reg #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic            shift,
  input  logic            serial_in,
  input  logic [WORD-1:0] load_data,
  output logic            serial_out,
  output logic [WORD-1:0] shifted
);

  logic [WORD-1:0] data_r;

  assign serial_out = data_r[WORD-1];
  assign shifted    = {data_r[WORD-2:0], serial_in};

  // Shift register storage: clear beats load, load beats shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
    end else if (clr) begin
      data_r <= '0;
    end else if (load) begin
      data_r <= load_data;
    end else if (shift) begin
      data_r <= shifted;
    end else begin
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/off_chip_spi_flash_device.sv
// Behavioural SPI flash slave: WRITE/READ/STATUS commands over a 1-bit
// serial link framed by CSbar, backed by a DEPTH x WORD register array and
// an 8-bit count of completed writes. DO is registered and is 0 outside
// READ data and STATUS output phases.
module off_chip_spi_flash_device
  import off_chip_spi_flash_device_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WORD  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic CSbar,
  input  logic DI,
  output logic DO
);

  // Word index width; DEPTH is a power of two between 2 and 256.
  localparam int IDX_W = $clog2(DEPTH);
  // Bit-counter values at the last write bit and after the last read bit.
  localparam logic [5:0] WDATA_LAST = 6'(WORD - 1);
  localparam logic [5:0] RDATA_END  = 6'(WORD);

  logic [2:0]       state_r, state_s;
  logic [5:0]       cnt_r, cnt_s;
  logic             do_r, do_s;
  logic [7:0]       wcount_r;
  logic             armed_r;
  logic             is_read_r, is_read_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [WORD-1:0]  mem_r [DEPTH];

  logic             sr_clr_s, sr_load_s, sr_shift_s;
  logic [WORD-1:0]  sr_load_data_s;
  logic [WORD-1:0]  sr_next_s;
  logic             sr_out_s;
  logic             mem_we_s;
  logic [WORD-1:0]  rd_word_s;

  off_chip_spi_flash_shift_reg #(.WORD(WORD)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .clr        (sr_clr_s),
    .load       (sr_load_s),
    .shift      (sr_shift_s),
    .serial_in  (DI),
    .load_data  (sr_load_data_s),
    .serial_out (sr_out_s),
    .shifted    (sr_next_s)
  );

  // On the last address bit the index is the low bits of the byte being completed.
  assign rd_word_s = mem_r[sr_next_s[IDX_W-1:0]];
  assign DO        = do_r;

  // Next-state, counter, output and shift-register control for one frame.
  always_comb begin
    state_s        = state_r;
    cnt_s          = cnt_r;
    do_s           = 1'b0;
    is_read_s      = is_read_r;
    idx_s          = idx_r;
    sr_clr_s       = 1'b0;
    sr_load_s      = 1'b0;
    sr_shift_s     = 1'b0;
    sr_load_data_s = '0;
    mem_we_s       = 1'b0;
    if (CSbar) begin
      state_s  = ST_IDLE;
      cnt_s    = 6'd0;
      sr_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A frame only starts once CSbar has been seen high since reset.
          if (armed_r) begin
            state_s    = ST_OPCODE;
            cnt_s      = 6'd1;
            sr_shift_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_OPCODE: begin
          sr_shift_s = 1'b1;
          if (cnt_r == OPCODE_LAST) begin
            is_read_s = (sr_next_s[7:0] == OP_READ);
            state_s   = opcode_next_state(sr_next_s[7:0]);
            if (state_s == ST_STATUS) begin
              // MSB goes out now; the rest is parked MSB-aligned in the shifter.
              do_s           = wcount_r[7];
              cnt_s          = 6'd1;
              sr_load_s      = 1'b1;
              sr_load_data_s = {wcount_r[6:0], {(WORD - 7){1'b0}}};
            end else begin
              cnt_s = 6'd0;
            end
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_ADDR: begin
          sr_shift_s = 1'b1;
          if (cnt_r == ADDR_LAST) begin
            idx_s = sr_next_s[IDX_W-1:0];
            if (is_read_r) begin
              state_s        = ST_RDATA;
              cnt_s          = 6'd1;
              do_s           = rd_word_s[WORD-1];
              sr_load_s      = 1'b1;
              sr_load_data_s = {rd_word_s[WORD-2:0], 1'b0};
            end else begin
              state_s = ST_WDATA;
              cnt_s   = 6'd0;
            end
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_WDATA: begin
          sr_shift_s = 1'b1;
          if (cnt_r == WDATA_LAST) begin
            mem_we_s = 1'b1;
            state_s  = ST_IGNORE;
            cnt_s    = 6'd0;
          end else begin
            cnt_s = cnt_r + 6'd1;
          end
        end
        ST_RDATA: begin
          if (cnt_r == RDATA_END) begin
            state_s = ST_IGNORE;
            cnt_s   = 6'd0;
          end else begin
            do_s       = sr_out_s;
            sr_shift_s = 1'b1;
            cnt_s      = cnt_r + 6'd1;
          end
        end
        ST_STATUS: begin
          if (cnt_r == STATUS_END) begin
            state_s = ST_IGNORE;
            cnt_s   = 6'd0;
          end else begin
            do_s       = sr_out_s;
            sr_shift_s = 1'b1;
            cnt_s      = cnt_r + 6'd1;
          end
        end
        ST_IGNORE: begin
          state_s = ST_IGNORE;
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = 6'd0;
        end
      endcase
    end
  end

  // FSM, counters, DO register and the arm flag that gates frame start after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 6'd0;
      do_r      <= 1'b0;
      wcount_r  <= 8'd0;
      armed_r   <= 1'b0;
      is_read_r <= 1'b0;
      idx_r     <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      do_r      <= do_s;
      armed_r   <= armed_r | CSbar;
      is_read_r <= is_read_s;
      idx_r     <= idx_s;
      if (mem_we_s) begin
        wcount_r <= wcount_r + 8'd1;
      end else begin
        wcount_r <= wcount_r;
      end
    end
  end

  // Storage array: cleared by reset, written on the last data bit of a WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (mem_we_s) begin
      mem_r[idx_r] <= sr_next_s;
    end
  end

endmodule
